// File: rtl/joybus_reply_sequencer.sv
// Joybus reply sequencer: picks the reply payload for a decoded console
// command, waits a turnaround, then drives the payload MSB-first as Joybus
// wire levels followed by the controller STOP bit. The line is released
// whenever no reply is in flight.
module joybus_reply_sequencer #(
    parameter int unsigned LEVEL_WIDTH = 2,
    parameter int unsigned TURNAROUND  = 4,
    parameter logic [23:0] INFO_RESP   = 24'h050000
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_byte,
    input  logic [31:0] button_state,
    output logic        data_tx,
    output logic        data_tx_oe,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic        cmd_drop
);

    localparam int unsigned LVL_CNT_W  = 4;
    localparam int unsigned BIT_CNT_W  = 6;
    localparam int unsigned TURN_CNT_W = 8;
    localparam int unsigned SHIFT_W    = 32;

    localparam logic [LVL_CNT_W-1:0]  LVL_LAST  = LVL_CNT_W'(LEVEL_WIDTH - 1);
    localparam logic [TURN_CNT_W-1:0] TURN_LAST = TURN_CNT_W'(TURNAROUND - 1);

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_SEND = 2'd2,
        S_STOP = 2'd3
    } state_e;

    state_e                 state_q,    state_d;
    logic [LVL_CNT_W-1:0]   lvl_cnt_q,  lvl_cnt_d;
    logic [1:0]             lvl_idx_q,  lvl_idx_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [TURN_CNT_W-1:0]  turn_cnt_q, turn_cnt_d;
    logic [SHIFT_W-1:0]     shift_q,    shift_d;
    logic                   data_tx_q,  data_tx_d;
    logic                   oe_q,       oe_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   err_q,      err_d;
    logic                   drop_q,     drop_d;

    // State, counters, payload and registered line outputs.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            lvl_cnt_q  <= '0;
            lvl_idx_q  <= '0;
            bit_cnt_q  <= '0;
            turn_cnt_q <= '0;
            shift_q    <= '0;
            data_tx_q  <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_cnt_q  <= lvl_cnt_d;
            lvl_idx_q  <= lvl_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            shift_q    <= shift_d;
            data_tx_q  <= data_tx_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state, counter sequencing and next output levels.
    always_comb begin
        state_d    = state_q;
        lvl_cnt_d  = lvl_cnt_q;
        lvl_idx_d  = lvl_idx_q;
        bit_cnt_d  = bit_cnt_q;
        turn_cnt_d = turn_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        drop_d     = 1'b0;
        data_tx_d  = 1'b1;
        oe_d       = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_byte == CMD_INFO || cmd_byte == CMD_RESET) begin
                        shift_d    = {INFO_RESP, 8'h00};
                        bit_cnt_d  = BIT_CNT_W'(24);
                        turn_cnt_d = '0;
                        state_d    = S_TURN;
                    end else if (cmd_byte == CMD_STATUS) begin
                        shift_d    = button_state;
                        bit_cnt_d  = BIT_CNT_W'(32);
                        turn_cnt_d = '0;
                        state_d    = S_TURN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_TURN: begin
                drop_d = cmd_valid;
                if (turn_cnt_q == TURN_LAST) begin
                    lvl_cnt_d = '0;
                    lvl_idx_d = '0;
                    state_d   = S_SEND;
                end else begin
                    turn_cnt_d = turn_cnt_q + TURN_CNT_W'(1);
                end
            end
            S_SEND: begin
                drop_d = cmd_valid;
                if (lvl_cnt_q == LVL_LAST) begin
                    lvl_cnt_d = '0;
                    if (lvl_idx_q == 2'd3) begin
                        lvl_idx_d = '0;
                        if (bit_cnt_q == BIT_CNT_W'(1)) begin
                            state_d = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                            shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
                        end
                    end else begin
                        lvl_idx_d = lvl_idx_q + 2'd1;
                    end
                end else begin
                    lvl_cnt_d = lvl_cnt_q + LVL_CNT_W'(1);
                end
            end
            S_STOP: begin
                drop_d = cmd_valid;
                if (lvl_cnt_q == LVL_LAST) begin
                    lvl_cnt_d = '0;
                    if (lvl_idx_q == 2'd2) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        lvl_idx_d = lvl_idx_q + 2'd1;
                    end
                end else begin
                    lvl_cnt_d = lvl_cnt_q + LVL_CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line levels derive from the upcoming state so they stay registered.
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_SEND: begin
                oe_d = 1'b1;
                case (lvl_idx_d)
                    2'd0:    data_tx_d = 1'b0;
                    2'd3:    data_tx_d = 1'b1;
                    default: data_tx_d = shift_d[SHIFT_W-1];
                endcase
            end
            S_STOP: begin
                oe_d      = 1'b1;
                data_tx_d = (lvl_idx_d == 2'd2);
            end
            default: begin
                oe_d      = 1'b0;
                data_tx_d = 1'b1;
            end
        endcase
    end

    assign data_tx    = data_tx_q;
    assign data_tx_oe = oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_err    = err_q;
    assign cmd_drop   = drop_q;

endmodule

// File: tb/tb_joybus_reply_sequencer.sv
// Directed bench for joybus_reply_sequencer: every reply is checked cycle by
// cycle against a waveform built from the Joybus bit encoding.
module tb_joybus_reply_sequencer;

    localparam int LW = 2;
    localparam int T  = 4;

    logic        sample_clk;
    logic        reset_n;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic [31:0] button_state;
    logic        data_tx;
    logic        data_tx_oe;
    logic        busy;
    logic        done;
    logic        cmd_err;
    logic        cmd_drop;

    int n_cmp = 0;
    int n_bad = 0;

    joybus_reply_sequencer #(
        .LEVEL_WIDTH (LW),
        .TURNAROUND  (T),
        .INFO_RESP   (24'h050000)
    ) dut (
        .sample_clk   (sample_clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .button_state (button_state),
        .data_tx      (data_tx),
        .data_tx_oe   (data_tx_oe),
        .busy         (busy),
        .done         (done),
        .cmd_err      (cmd_err),
        .cmd_drop     (cmd_drop)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] btn;
        int          bits;     // 0 => unsupported command
        logic [31:0] payload;  // expected bits, MSB-aligned
        int          drop_at;  // cycle at which a stray cmd_valid is sent, -1 none
        bit          chg_btn;  // change button_state right after acceptance
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s c=%0d: got %0h expected %0h (t=%0t)", name, c, act, exp, $time);
        end
    endtask

    // Expected wire level t cycles after the line is first driven.
    function automatic logic exp_level(input int t, input int bits, input logic [31:0] p);
        int bi, lv, s;
        if (t < bits * 4 * LW) begin
            bi = t / (4 * LW);
            lv = (t % (4 * LW)) / LW;
            if (lv == 0) return 1'b0;
            if (lv == 3) return 1'b1;
            return p[31 - bi];
        end
        s = (t - bits * 4 * LW) / LW;
        return (s == 2);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sample_clk);
            #1;
        end
    endtask

    // Presents one command and checks every cycle up to the done cycle.
    // Returns in the done cycle without advancing, so a follow-up call
    // presents its command while done is high.
    task automatic run_reply(input logic [7:0] cmd, input logic [31:0] btn,
                             input int bits, input logic [31:0] pay,
                             input int drop_at, input bit chg, input int abort_at);
        int total, last;
        total = bits * 4 * LW + 3 * LW;
        last  = (bits == 0) ? 0 : T + total;
        cmd_valid    = 1'b1;
        cmd_byte     = cmd;
        button_state = btn;
        @(posedge sample_clk);
        #1;
        cmd_valid = 1'b0;
        if (chg) button_state = ~btn;
        for (int c = 0; c <= last; c++) begin
            logic e_busy, e_oe;
            e_busy = (bits != 0) && (c < T + total);
            e_oe   = (bits != 0) && (c >= T) && (c < T + total);
            chk("busy", c, 32'(busy), 32'(e_busy));
            chk("oe", c, 32'(data_tx_oe), 32'(e_oe));
            chk("done", c, 32'(done), 32'((bits != 0) && (c == T + total)));
            chk("cmd_err", c, 32'(cmd_err), 32'((bits == 0) && (c == 0)));
            chk("cmd_drop", c, 32'(cmd_drop), 32'((drop_at >= 0) && (c == drop_at + 1)));
            if (e_oe)
                chk("data_tx", c, 32'(data_tx), 32'(exp_level(c - T, bits, pay)));
            else if (!e_busy)
                chk("data_tx_idle", c, 32'(data_tx), 32'(1));
            if (c == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk("abort_oe", c, 32'(data_tx_oe), 32'(0));
                chk("abort_busy", c, 32'(busy), 32'(0));
                chk("abort_tx", c, 32'(data_tx), 32'(1));
                chk("abort_done", c, 32'(done), 32'(0));
                idle(2);
                reset_n = 1'b1;
                return;
            end
            if (c < last) begin
                cmd_valid = (c == drop_at);
                cmd_byte  = 8'h01;
                @(posedge sample_clk);
                #1;
                cmd_valid = 1'b0;
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_byte     = 8'h00;
        button_state = 32'h0;

        vecs[0] = '{8'h00, 32'h0000_0000, 24, 32'h0500_0000, -1, 1'b0};
        vecs[1] = '{8'h01, 32'h8000_0001, 32, 32'h8000_0001, -1, 1'b1};
        vecs[2] = '{8'h02, 32'h0000_0000, 0,  32'h0,         -1, 1'b0};
        vecs[3] = '{8'h00, 32'hFFFF_FFFF, 24, 32'h0500_0000, 50, 1'b0};
        vecs[4] = '{8'hFF, 32'h1234_5678, 24, 32'h0500_0000, 1,  1'b0};
        vecs[5] = '{8'h01, 32'hA5C3_0F1E, 32, 32'hA5C3_0F1E, 2,  1'b1};
        vecs[6] = '{8'h7F, 32'h0000_0000, 0,  32'h0,         -1, 1'b0};
        vecs[7] = '{8'hFE, 32'h0000_0000, 0,  32'h0,         -1, 1'b0};

        // Reset values held while reset is asserted.
        idle(2);
        chk("rst_tx", 0, 32'(data_tx), 32'(1));
        chk("rst_oe", 0, 32'(data_tx_oe), 32'(0));
        chk("rst_busy", 0, 32'(busy), 32'(0));
        chk("rst_done", 0, 32'(done), 32'(0));
        chk("rst_err", 0, 32'(cmd_err), 32'(0));
        chk("rst_drop", 0, 32'(cmd_drop), 32'(0));
        reset_n = 1'b1;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            run_reply(vecs[i].cmd, vecs[i].btn, vecs[i].bits, vecs[i].payload,
                      vecs[i].drop_at, vecs[i].chg_btn, -1);
            idle(3);
        end

        // Unsupported command immediately followed by RESET.
        run_reply(8'h02, 32'h0, 0, 32'h0, -1, 1'b0, -1);
        run_reply(8'hFF, 32'h0, 24, 32'h0500_0000, -1, 1'b0, -1);
        idle(3);

        // Reset mid-bit, then a clean INFO restart.
        run_reply(8'h00, 32'h0, 24, 32'h0500_0000, -1, 1'b0, 100);
        idle(2);
        chk("post_rst_busy", 0, 32'(busy), 32'(0));
        run_reply(8'h00, 32'h0, 24, 32'h0500_0000, -1, 1'b0, -1);
        idle(3);

        // Back-to-back: STATUS presented in the done cycle of INFO, then again.
        run_reply(8'h00, 32'h0, 24, 32'h0500_0000, -1, 1'b0, -1);
        run_reply(8'h01, 32'h0F0F_3C3C, 32, 32'h0F0F_3C3C, -1, 1'b0, -1);
        run_reply(8'h01, 32'h8000_0000, 32, 32'h8000_0000, -1, 1'b1, -1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/joybus_reply_sequencer.md
Name: joybus_reply_sequencer

Overview:
Transmit-side controller for the fake N64 controller. Accepts a decoded console command byte from the receive path, chooses the reply payload, waits a fixed turnaround, then serialises the payload MSB-first as Joybus wire levels and ends with the controller STOP bit. Owns the data line output enable, so the line is released (Z) whenever no reply is in flight.

Parameters:
LEVEL_WIDTH, 2, sample_clk cycles per wire level; a bit is 4 levels (BIT_WIDTH = 4*LEVEL_WIDTH); legal range 1..15
TURNAROUND, 4, idle cycles between command acceptance and the first driven level; legal range 1..255
INFO_RESP, 24'h050000, 3-byte reply to INFO (0x00) and RESET (0xFF)

Ports:
sample_clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  one-cycle strobe: cmd_byte holds a complete command from the receive path
cmd_byte  input  8  decoded console command
button_state  input  32  STATUS payload; sampled only at acceptance
data_tx  output  1  level to drive when data_tx_oe=1 (0=L, 1=H)
data_tx_oe  output  1  1=drive data line, 0=release (Z)
busy  output  1  reply in progress (TURN/SEND/STOP)
done  output  1  one-cycle pulse: reply complete
cmd_err  output  1  one-cycle pulse: unsupported command ignored
cmd_drop  output  1  one-cycle pulse: cmd_valid arrived while busy

Behaviour:
- Reset (async, reset_n=0): state IDLE; data_tx=1, data_tx_oe=0, busy=0, done=0, cmd_err=0, cmd_drop=0; counters and shift register cleared. Asserting reset mid-reply releases the line immediately, with no STOP bit.
- States: IDLE -> TURN -> SEND -> STOP -> IDLE.
- IDLE: on an edge with cmd_valid=1:
  - 0x00 or 0xFF: load INFO_RESP; bit count 24.
  - 0x01: load button_state; bit count 32.
  - Any other byte: stay IDLE; cmd_err=1 for the following cycle.
  - On a valid command, go to TURN; busy=1 from the next cycle.
- TURN: count TURNAROUND cycles with data_tx_oe=0, then go to SEND.
- SEND: for each bit, MSB first, drive 4 levels of LEVEL_WIDTH cycles each with data_tx_oe=1.
  - Logical 0: L,L,L,H.
  - Logical 1: L,H,H,H.
  - Go to STOP after the last bit.
- STOP: drive L,L,H (3*LEVEL_WIDTH cycles), then the 4th level is release. Go to IDLE: data_tx_oe=0, data_tx=1, busy=0, done=1 for exactly that first IDLE cycle.
- Timing: if cmd_valid is sampled at edge k, data_tx_oe rises after edge k+TURNAROUND. Line activity lasts bits*4*LEVEL_WIDTH + 3*LEVEL_WIDTH cycles. done is high after edge k+TURNAROUND+that duration.
- Levels change only on LEVEL_WIDTH boundaries; no glitches, and data_tx is registered.
- cmd_valid while busy: ignored, and payload and timing are unaffected. cmd_drop=1 in the next cycle. This includes cmd_valid during TURN.
- A new command is accepted in the same cycle done is high (the state is IDLE), giving back-to-back replies.
- button_state changes after acceptance must not alter the reply in flight.
- Counter widths:
  - Level counter: 4 bits.
  - Bit counter: 6 bits (up to 32).
  - Turnaround counter: 8 bits.
  - No wrap-around may occur within legal parameter ranges.

Test Plan:
1. INFO, defaults: cmd_byte=0x00 at edge 0 -> oe=1 from edge 4; first byte 0x05 bits 00000101 show levels LLLH x5, LHHH, LLLH, LHHH; 24 bits then L,L,H; done pulse after edge 202; busy is 1 over edges 1..202.
2. STATUS: button_state=32'h8000_0001, cmd 0x01 at edge 0, button_state changed to 0 at edge 1 -> first bit is LHHH, bits 2..31 are LLLH, last bit is LHHH; done after edge 4+262=266.
3. Unsupported cmd 0x02 -> cmd_err=1 for one cycle after the edge; busy and oe stay 0; a following 0xFF at the next cycle produces a full INFO reply.
4. cmd_valid=1 (0x01) at edge 50 during the INFO reply -> cmd_drop pulse after edge 50; the INFO waveform is identical to scenario 1.
5. reset_n low at edge 100 (mid-bit) -> oe=0, busy=0 asynchronously; after release, a 0x00 command restarts with correct timing.
6. Back-to-back: a second 0x01 presented in the done cycle -> accepted; oe rises TURNAROUND cycles later; no cmd_drop.
